// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver with a valid/ready byte output, framing-error and overrun pulses.
// Define UART_RX_MAJORITY_EN to take a 3-sample majority vote at every sample point.
module uart_rx #(
  parameter int unsigned clk_freq  = 12000000,
  parameter int unsigned baud_rate = 115200,
  parameter int unsigned width     = 8
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       rx,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int unsigned P = clk_freq / baud_rate - 1;
  localparam int unsigned H = P / 2;
  localparam logic [width-1:0] P_CNT = width'(P);
  localparam logic [width-1:0] H_CNT = width'(H);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [width-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             sync1;
  logic             rs;
  logic             sample_c;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // Two previous rs values; with rs they form the 3-sample voting window.
  always_ff @(posedge clk) begin
    if (!nreset) hist <= 2'b11;
    else         hist <= {hist[0], rs};
  end

  assign sample_c = (rs & hist[0]) | (rs & hist[1]) | (hist[0] & hist[1]);
`else
  assign sample_c = rs;
`endif

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync1        <= 1'b1;
      rs           <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      sync1        <= rx;
      rs           <= sync1;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
      // A delivery later in this block overrides the handshake drop.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rs) state <= START;
        end
        START: begin
          if (cnt == H_CNT) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sample_c ? IDLE : DATA;
          end else begin
            cnt <= cnt + width'(1);
          end
        end
        DATA: begin
          if (cnt == P_CNT) begin
            cnt   <= '0;
            shreg <= {sample_c, shreg[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + width'(1);
          end
        end
        STOP: begin
          if (cnt == P_CNT) begin
            cnt   <= '0;
            state <= IDLE;
            if (!sample_c) begin
              rx_frame_err <= 1'b1;
            end else if (!rx_valid || rx_ready) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              rx_overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + width'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (104 clocks per bit).
module tb_uart_rx;

  localparam int BIT = 104;

  logic       clk      = 1'b0;
  logic       nreset   = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b1;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       rx_overrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;

  logic [7:0] got_q[$];
  int   fe_cnt    = 0;
  int   ov_cnt    = 0;
  int   valid_cyc = 0;
  int   rise_cyc  = 0;
  logic valid_d   = 1'b0;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk          (clk),
    .nreset       (nreset),
    .rx           (rx),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: accepted bytes, pulse-high cycles, rx_valid rise time.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_frame_err) fe_cnt <= fe_cnt + 1;
    if (rx_overrun)   ov_cnt <= ov_cnt + 1;
    if (rx_valid)     valid_cyc <= valid_cyc + 1;
    if (rx_valid && !valid_d) rise_cyc <= cyc;
    valid_d <= rx_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input logic glitch);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < BIT; c++) begin
        rx = (glitch && i >= 1 && i <= 8 && c == 52) ? 1'b1 : fr[i];
        if (i == 0 && c == 0) t0 = cyc;
        tick(1);
      end
    end
    rx = 1'b1;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    rx     = 1'b1;
    tick(5);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", rx_frame_err); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", rx_overrun); end
    nreset = 1'b1;
    tick(5);
  endtask

  task automatic test_idle;
    int v0, f0, o0;
    v0 = valid_cyc; f0 = fe_cnt; o0 = ov_cnt;
    tick(2000);
    checks++; if (valid_cyc - v0 !== 0) begin errors++; $display("FAIL idle_valid: got %0d cycles expected 0", valid_cyc - v0); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL idle_ferr: got %0d expected 0", fe_cnt - f0); end
    checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL idle_ovr: got %0d expected 0", ov_cnt - o0); end
  endtask

  task automatic test_single;
    int q0, lat;
    q0 = got_q.size();
    send_byte(8'h55, 1'b1, 1'b0);
    tick(200);
    lat = rise_cyc - t0;
    checks++; if (got_q.size() - q0 !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", got_q.size() - q0); end
    checks++; if (got_q.size() <= q0 || got_q[q0] !== 8'h55) begin errors++; $display("FAIL single_data: got %h expected 55", (got_q.size() > q0) ? got_q[q0] : 8'hxx); end
    checks++; if (lat < 989 || lat > 991) begin errors++; $display("FAIL single_latency: got %0d expected 990+/-1", lat); end
  endtask

  task automatic test_back_to_back;
    int q0, f0, o0;
    q0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt;
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    tick(200);
    checks++; if (got_q.size() - q0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", got_q.size() - q0); end
    checks++; if (got_q.size() <= q0 || got_q[q0] !== 8'hA5) begin errors++; $display("FAIL b2b_first: got %h expected a5", (got_q.size() > q0) ? got_q[q0] : 8'hxx); end
    checks++; if (got_q.size() <= q0 + 1 || got_q[q0+1] !== 8'h3C) begin errors++; $display("FAIL b2b_second: got %h expected 3c", (got_q.size() > q0 + 1) ? got_q[q0+1] : 8'hxx); end
    checks++; if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) begin errors++; $display("FAIL b2b_errors: got %0d expected 0", (fe_cnt - f0) + (ov_cnt - o0)); end
  endtask

  task automatic test_false_start;
    int q0, f0;
    q0 = got_q.size(); f0 = fe_cnt;
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(300);
    checks++; if (got_q.size() - q0 !== 0) begin errors++; $display("FAIL false_start_valid: got %0d bytes expected 0", got_q.size() - q0); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL false_start_ferr: got %0d expected 0", fe_cnt - f0); end
    send_byte(8'h81, 1'b1, 1'b0);
    tick(200);
    checks++; if (got_q.size() <= q0 || got_q[q0] !== 8'h81) begin errors++; $display("FAIL false_start_next: got %h expected 81", (got_q.size() > q0) ? got_q[q0] : 8'hxx); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = valid_cyc; f0 = fe_cnt;
    send_byte(8'hF0, 1'b0, 1'b0);
    tick(300);
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL frame_err_pulse: got %0d cycles expected 1", fe_cnt - f0); end
    checks++; if (valid_cyc - v0 !== 0) begin errors++; $display("FAIL frame_err_valid: got %0d cycles expected 0", valid_cyc - v0); end
  endtask

  task automatic test_overrun;
    int q0, o0;
    q0 = got_q.size(); o0 = ov_cnt;
    rx_ready = 1'b0;
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    tick(200);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", rx_valid); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data_held: got %h expected 11", rx_data); end
    checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulse: got %0d cycles expected 1", ov_cnt - o0); end
    rx_ready = 1'b1;
    tick(1);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_fall: got %b expected 0", rx_valid); end
    checks++; if (got_q.size() - q0 !== 1) begin errors++; $display("FAIL ovr_accept_count: got %0d expected 1", got_q.size() - q0); end
    checks++; if (got_q.size() <= q0 || got_q[q0] !== 8'h11) begin errors++; $display("FAIL ovr_accept_data: got %h expected 11", (got_q.size() > q0) ? got_q[q0] : 8'hxx); end
  endtask

  task automatic test_reset_mid;
    int q0;
    q0 = got_q.size();
    rx = 1'b0;
    tick(BIT);
    rx = 1'b1;
    tick(3 * BIT + 20);
    nreset = 1'b0;
    tick(1);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", rx_data); end
    checks++; if ((rx_frame_err | rx_overrun) !== 1'b0) begin errors++; $display("FAIL midrst_pulses: got %b expected 0", rx_frame_err | rx_overrun); end
    nreset = 1'b1;
    tick(1200);
    checks++; if (got_q.size() - q0 !== 0) begin errors++; $display("FAIL midrst_nobyte: got %0d bytes expected 0", got_q.size() - q0); end
    send_byte(8'h77, 1'b1, 1'b0);
    tick(200);
    checks++; if (got_q.size() <= q0 || got_q[q0] !== 8'h77) begin errors++; $display("FAIL midrst_next: got %h expected 77", (got_q.size() > q0) ? got_q[q0] : 8'hxx); end
  endtask

  task automatic test_glitch;
    int q0;
    logic [7:0] exp_b;
`ifdef UART_RX_MAJORITY_EN
    exp_b = 8'h00;
`else
    exp_b = 8'hFF;
`endif
    q0 = got_q.size();
    send_byte(8'h00, 1'b1, 1'b1);
    tick(200);
    checks++; if (got_q.size() - q0 !== 1) begin errors++; $display("FAIL glitch_count: got %0d expected 1", got_q.size() - q0); end
    checks++; if (got_q.size() <= q0 || got_q[q0] !== exp_b) begin errors++; $display("FAIL glitch_data: got %h expected %h", (got_q.size() > q0) ? got_q[q0] : 8'hxx, exp_b); end
  endtask

  initial begin
    test_reset;
    test_idle;
    test_single;
    test_back_to_back;
    test_false_start;
    test_frame_err;
    test_overrun;
    test_reset_mid;
    test_glitch;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
